// File: rtl/alu_pkg.sv
// Opcode map and FSM state encoding shared by the
// execute-stage ALU and its iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX
  } state_e;

  function automatic logic is_md(
    input logic [3:0] op
  );
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_iter_mdu.sv
// Iterative shift-add multiplier / restoring divider on
// operand magnitudes; one step per cycle, signs fixed on output.
module alu_iter_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  logic             r_run;
  logic             r_div;
  logic             r_nq;
  logic             r_nr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rs;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [2*WIDTH-1:0] w_pneg;

  assign w_sa = i_signed & i_a[WIDTH-1];
  assign w_sb = i_signed & i_b[WIDTH-1];
  assign w_ma = w_sa ? -i_a : i_a;
  assign w_mb = w_sb ? -i_b : i_b;

  assign w_sum = {1'b0, r_hi}
               + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_rs  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge  = w_rs >= {1'b0, r_m};
  assign w_sub = w_rs[WIDTH-1:0] - r_m;

  assign o_done = r_run
                & (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_div <= 1'b0;
      r_nq  <= 1'b0;
      r_nr  <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_m   <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_div <= i_div;
      r_nq  <= w_sa ^ w_sb;
      r_nr  <= w_sa;
      r_cnt <= '0;
      r_hi  <= '0;
      r_m   <= i_div ? w_mb : w_ma;
      r_lo  <= i_div ? w_ma : w_mb;
    end else if (r_run) begin
      if (r_div) begin
        r_hi <= w_ge ? w_sub : w_rs[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], w_ge};
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
      if (o_done) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // product is negated as a whole; quotient and remainder separately
  assign w_pneg = -{r_hi, r_lo};

  assign o_hi = r_div
    ? (r_nr ? -r_hi : r_hi)
    : (r_nq ? w_pneg[2*WIDTH-1:WIDTH] : r_hi);

  assign o_lo = r_div
    ? (r_nq ? -r_lo : r_lo)
    : (r_nq ? w_pneg[WIDTH-1:0] : r_lo);

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with HI/LO registers; MULT/DIV ops are
// sequenced through the iterative unit with a valid/ready stall.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op
);

  state_e r_state;
  state_e w_next;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mda;
  logic             r_mdbz;
  logic             r_valid;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dbz;
  logic             r_ill;

  logic             w_acc;
  logic             w_md;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;
  logic             w_done;
  logic [WIDTH-1:0] w_mhi;
  logic [WIDTH-1:0] w_mlo;
  logic [WIDTH-1:0] w_fhi;
  logic [WIDTH-1:0] w_flo;

  assign in_ready = (r_state == S_IDLE);
  assign w_acc    = in_valid & in_ready;
  assign w_md     = w_acc & is_md(alu_op);
  assign w_sum    = op_a + op_b;
  assign w_dif    = op_a - op_b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (alu_op)
      OP_AND: w_res = op_a & op_b;
      OP_OR:  w_res = op_a | op_b;
      OP_NOR: w_res = ~(op_a | op_b);
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1])
              & (w_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1])
              & (w_dif[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}},
                       $signed(op_a) < $signed(op_b)};
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
      OP_MULT, OP_MULTU,
      OP_DIV, OP_DIVU: w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_md) w_next = S_BUSY;
      S_BUSY:  if (w_done) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  alu_iter_mdu #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_start (w_md),
    .i_div   (alu_op[1]),
    .i_signed(~alu_op[0]),
    .i_a     (op_a),
    .i_b     (op_b),
    .o_done  (w_done),
    .o_hi    (w_mhi),
    .o_lo    (w_mlo)
  );

  // divide by zero bypasses the iterative result entirely
  assign w_fhi = r_mdbz ? r_mda : w_mhi;
  assign w_flo = r_mdbz ? '1 : w_mlo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mda    <= '0;
      r_mdbz   <= 1'b0;
      r_valid  <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_md) begin
        r_mda  <= op_a;
        r_mdbz <= alu_op[1] & (op_b == '0);
      end else if (w_acc) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_ovf    <= w_ovf;
        r_dbz    <= 1'b0;
        r_ill    <= w_ill;
        r_valid  <= 1'b1;
      end
      if (r_state == S_FIX) begin
        r_hi     <= w_fhi;
        r_lo     <= w_flo;
        r_result <= w_flo;
        r_zero   <= (w_flo == '0);
        r_ovf    <= 1'b0;
        r_dbz    <= r_mdbz;
        r_ill    <= 1'b0;
        r_valid  <= 1'b1;
      end
    end
  end

  assign out_valid   = r_valid;
  assign result      = r_result;
  assign zero        = r_zero;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;
  assign illegal_op  = r_ill;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench: directed WIDTH=32 steps, then a WIDTH=8
// random sweep with in_valid toggling while the unit is busy.
module tb_alu_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          acc;
    int          edg;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  longint unsigned hi32 = 0, lo32 = 0;
  longint unsigned hi8 = 0, lo8 = 0;

  logic        v32, rdy32, ov32, z32, o32, d32, i32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        v8, rdy8, ov8, z8, o8, d8, i8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8;

  alu_mdu #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(rst_n),
    .in_valid(v32), .in_ready(rdy32),
    .op_a(a32), .op_b(b32), .alu_op(op32),
    .out_valid(ov32), .result(res32), .zero(z32),
    .overflow(o32), .div_by_zero(d32), .illegal_op(i32)
  );

  alu_mdu #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(rst_n),
    .in_valid(v8), .in_ready(rdy8),
    .op_a(a8), .op_b(b8), .alu_op(op8),
    .out_valid(ov8), .result(res8), .zero(z8),
    .overflow(o8), .div_by_zero(d8), .illegal_op(i8)
  );

  function automatic void model(
    input  int              w,
    input  logic [3:0]      op,
    input  longint unsigned a,
    input  longint unsigned b,
    inout  longint unsigned hi,
    inout  longint unsigned lo,
    output logic [31:0]     r,
    output logic [3:0]      fl
  );
    longint unsigned m, mn, rr, pu;
    longint sa, sb, p;
    logic o, d, il;
    m  = (64'd1 << w) - 64'd1;
    mn = 64'd1 << (w - 1);
    sa = ((a & mn) != 0) ? $signed(a) - $signed(m) - 1 : $signed(a);
    sb = ((b & mn) != 0) ? $signed(b) - $signed(m) - 1 : $signed(b);
    rr = 0; o = 0; d = 0; il = 0;
    case (op)
      4'b0000: rr = a & b;
      4'b0001: rr = a | b;
      4'b0010: begin
        rr = (a + b) & m;
        o = ((a & mn) == (b & mn)) && ((rr & mn) != (a & mn));
      end
      4'b0110: begin
        rr = (a - b) & m;
        o = ((a & mn) != (b & mn)) && ((rr & mn) != (a & mn));
      end
      4'b0111: rr = (sa < sb) ? 64'd1 : 64'd0;
      4'b1100: rr = ~(a | b) & m;
      4'b1000: begin
        p = sa * sb;
        hi = ($unsigned(p) >> w) & m;
        lo = $unsigned(p) & m;
        rr = lo;
      end
      4'b1001: begin
        pu = a * b;
        hi = (pu >> w) & m;
        lo = pu & m;
        rr = lo;
      end
      4'b1010: begin
        if (b == 0) begin
          lo = m; hi = a; d = 1;
        end else if (a == mn && sb == -1) begin
          lo = mn; hi = 0;
        end else begin
          lo = $unsigned(sa / sb) & m;
          hi = $unsigned(sa % sb) & m;
        end
        rr = lo;
      end
      4'b1011: begin
        if (b == 0) begin
          lo = m; hi = a; d = 1;
        end else begin
          lo = a / b; hi = a % b;
        end
        rr = lo;
      end
      4'b1101: rr = hi;
      4'b1110: rr = lo;
      default: il = 1;
    endcase
    r  = rr[31:0];
    fl = {rr == 0, o, d, il};
  endfunction

  task automatic issue32(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          waited
  );
    logic [31:0] r;
    logic [3:0]  fl;
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy32 && n < 200) begin
      n++;
      @(negedge clk);
    end
    waited = n;
    checks++;
    assert (rdy32 === 1'b1) else begin
      errors++;
      $error("FAIL ready32_timeout got %b want 1", rdy32);
    end
    model(32, op, a, b, hi32, lo32, r, fl);
    q32.push_back('{res: r, fl: fl, acc: cyc,
                    edg: (op[3:2] == 2'b10) ? 33 : 0});
    v32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk);
    #1 v32 = 1'b0;
  endtask

  task automatic issue8(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [31:0] r;
    logic [3:0]  fl;
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy8 && n < 200) begin
      v8  = 1'($urandom_range(0, 1));
      op8 = 4'($urandom);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      n++;
      @(negedge clk);
    end
    if ($urandom_range(0, 3) == 0) begin
      v8 = 1'b0;
      @(negedge clk);
    end
    checks++;
    assert (rdy8 === 1'b1) else begin
      errors++;
      $error("FAIL ready8_timeout got %b want 1", rdy8);
    end
    model(8, op, {56'd0, a}, {56'd0, b}, hi8, lo8, r, fl);
    q8.push_back('{res: r, fl: fl, acc: cyc,
                   edg: (op[3:2] == 2'b10) ? 9 : 0});
    v8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk);
    #1 v8 = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ov32) begin
      checks++;
      assert (q32.size() != 0) else begin
        errors++;
        $error("FAIL spurious32 got out_valid=1 want no pending op");
      end
      if (q32.size() != 0) begin
        e = q32.pop_front();
        checks++;
        assert ({res32, z32, o32, d32, i32} === {e.res, e.fl}) else begin
          errors++;
          $error("FAIL out32 got %h/%b want %h/%b",
                 res32, {z32, o32, d32, i32}, e.res, e.fl);
        end
        checks++;
        assert ((cyc - e.acc - 1) == e.edg) else begin
          errors++;
          $error("FAIL lat32 got edge %0d want %0d", cyc - e.acc - 1, e.edg);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov8) begin
      checks++;
      assert (q8.size() != 0) else begin
        errors++;
        $error("FAIL spurious8 got out_valid=1 want no pending op");
      end
      if (q8.size() != 0) begin
        e = q8.pop_front();
        checks++;
        assert ({24'd0, res8, z8, o8, d8, i8} === {e.res, e.fl}) else begin
          errors++;
          $error("FAIL out8 got %h/%b want %h/%b",
                 res8, {z8, o8, d8, i8}, e.res[7:0], e.fl);
        end
        checks++;
        assert ((cyc - e.acc - 1) == e.edg) else begin
          errors++;
          $error("FAIL lat8 got edge %0d want %0d", cyc - e.acc - 1, e.edg);
        end
      end
    end
  end

  initial begin
    int w;
    int t;
    rst_n = 1'b0;
    v32 = 0; op32 = 0; a32 = 0; b32 = 0;
    v8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(negedge clk);
    checks++;
    assert ({ov32, res32, z32, o32, d32, i32, rdy32} === {1'b0, 32'd0, 4'd0, 1'b1})
    else begin
      errors++;
      $error("FAIL reset32 got %b/%h/%b/%b want 0/0/0000/1",
             ov32, res32, {z32, o32, d32, i32}, rdy32);
    end
    checks++;
    assert ({ov8, res8, z8, o8, d8, i8, rdy8} === {1'b0, 8'd0, 4'd0, 1'b1})
    else begin
      errors++;
      $error("FAIL reset8 got %b/%h/%b/%b want 0/0/0000/1",
             ov8, res8, {z8, o8, d8, i8}, rdy8);
    end
    rst_n = 1'b1;

    issue32(4'b0010, 32'h7FFF_FFFF, 32'h1, w);
    issue32(4'b0111, 32'hFFFF_FFFF, 32'h1, w);
    issue32(4'b0110, 32'h8000_0000, 32'h1, w);
    issue32(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, w);
    issue32(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, w);
    issue32(4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00, w);
    checks++;
    assert (w == 0) else begin
      errors++;
      $error("FAIL b2b32 got wait %0d want 0", w);
    end

    issue32(4'b1000, 32'hFFFF_FFFD, 32'h5, w);
    issue32(4'b1101, 32'h0, 32'h0, w);
    checks++;
    assert (w == 33) else begin
      errors++;
      $error("FAIL busy32 got %0d stalled cycles want 33", w);
    end
    issue32(4'b1110, 32'h0, 32'h0, w);

    issue32(4'b1010, 32'hFFFF_FFF9, 32'h2, w);
    issue32(4'b1101, 32'h0, 32'h0, w);
    issue32(4'b1011, 32'h7, 32'h0, w);
    issue32(4'b1101, 32'h0, 32'h0, w);
    issue32(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, w);
    issue32(4'b1101, 32'h0, 32'h0, w);
    issue32(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
    issue32(4'b1101, 32'h0, 32'h0, w);
    issue32(4'b1010, 32'h7, 32'hFFFF_FFFE, w);
    issue32(4'b1101, 32'h0, 32'h0, w);
    issue32(4'b0101, 32'h1234, 32'h5678, w);

    issue32(4'b1001, 32'h1234_5678, 32'h9ABC_DEF0, w);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({ov32, res32, z32, o32, d32, i32, rdy32} === {1'b0, 32'd0, 4'd0, 1'b1})
    else begin
      errors++;
      $error("FAIL abort32 got %b/%h/%b/%b want 0/0/0000/1",
             ov32, res32, {z32, o32, d32, i32}, rdy32);
    end
    q32.delete();
    hi32 = 0;
    lo32 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue32(4'b1101, 32'h0, 32'h0, w);
    issue32(4'b1110, 32'h0, 32'h0, w);
    issue32(4'b0010, 32'h3, 32'h4, w);

    for (int k = 0; k < 80; k++) begin
      logic [7:0] ra, rb;
      case ($urandom_range(0, 5))
        0: ra = 8'h00;
        1: ra = 8'h80;
        2: ra = 8'hFF;
        default: ra = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rb = 8'h00;
        1: rb = 8'hFF;
        2: rb = 8'h01;
        default: rb = 8'($urandom);
      endcase
      issue8(4'($urandom_range(0, 15)), ra, rb);
    end

    t = 0;
    while ((q32.size() != 0 || q8.size() != 0) && t < 100) begin
      t++;
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    assert (q32.size() == 0 && q8.size() == 0) else begin
      errors++;
      $error("FAIL drain got %0d/%0d pending want 0/0",
             q32.size(), q8.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage ALU with an iterative multiply/divide unit and HI/LO registers.
- Basic ops (AND, OR, ADD, SUB, SLT, NOR) return a registered result after 1 cycle at full throughput.
- MULT/MULTU/DIV/DIVU run over WIDTH+1 cycles and write HI/LO; MFHI/MFLO read them back.
- A valid/ready handshake lets the pipeline stall while the multiply/divide unit is busy.

## Interface
- WIDTH, 32, datapath width in bits; must be ≥ 4.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  an operation is presented on op_a, op_b and alu_op.
- in_ready  out  1  the block can accept an operation this cycle.
- op_a  in  WIDTH  Read_data1 operand.
- op_b  in  WIDTH  Read_data2 operand.
- alu_op  in  4  operation code (see Operation).
- out_valid  out  1  single-cycle pulse; result and flags are valid.
- result  out  WIDTH  registered result, held until the next out_valid.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow; ADD and SUB only, 0 otherwise.
- div_by_zero  out  1  DIV/DIVU with op_b == 0.
- illegal_op  out  1  unused opcode was accepted.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0 or 1), 1100 NOR.
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU.
  - 1101 MFHI, 1110 MFLO.
  - Any other code: result 0, illegal_op=1.
- An operation is accepted on an edge with in_valid && in_ready.
- ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operand signs equal (ADD) or differ (SUB), and result sign differs from op_a.
- MULT/MULTU: {HI,LO} = full 2·WIDTH product. result = LO.
- DIV/DIVU: LO = quotient, HI = remainder. result = LO.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed MIN / −1: LO = MIN, HI = 0, overflow = 0.
  - Divide by zero: LO = all ones, HI = op_a, div_by_zero = 1.
- Signed mul/div: operate on magnitudes, then apply a sign fix.
- MFHI/MFLO: 1-cycle ops returning HI/LO. HI/LO change only when a MULT/DIV completes.
- States:
  - IDLE: in_ready=1. A basic op or MF* is registered; out_valid pulses next cycle. MULT/DIV → BUSY, counter = 0.
  - BUSY: in_ready=0. One shift-add (mul) or restoring-subtract (div) step per cycle; counter increments. Counter == WIDTH−1 → FIX.
  - FIX: in_ready=0. Apply signs, load HI/LO and result, pulse out_valid → IDLE.
- Flags are registered with result and hold until the next out_valid.
- Reset values:
  - result = 0, HI = 0, LO = 0.
  - All flags = 0, out_valid = 0, in_ready = 1.
  - State = IDLE, counter = 0.

## Timing
- Edge 0 = accepting edge.
- Basic/MF* op: out_valid high in the cycle after edge 0 (latency 1).
  - Back-to-back acceptance every cycle.
- MULT/DIV:
  - in_ready low from edge 0 through edge WIDTH+1.
  - out_valid pulses in the cycle after edge WIDTH+1 (latency WIDTH+1).
  - in_ready returns high in that same cycle.
- MFHI accepted immediately after a MULT completes returns the new HI.
- in_valid while in_ready = 0 is ignored. The upstream holds the op.
- Reset asserted mid-operation:
  - Aborts immediately; all outputs take their reset values asynchronously.
  - The partial HI/LO result is discarded.
- WIDTH is fixed at elaboration; the counter is clog2(WIDTH) bits and never wraps.

## Structure
- alu_pkg: opcode localparams and the state enum.
- Sub-module alu_iter_mdu:
  - Holds the counter, partial-product/remainder registers and the sign-fix step.
  - Handshake: start/done. The top level keeps the combinational ops, HI/LO, the flags and the FSM sequencing.

## Test plan
- WIDTH=32: ADD 0x7FFFFFFF + 0x1 → result 0x80000000, overflow=1, out_valid 1 cycle after accept. SLT 0xFFFFFFFF, 0x1 → result 1.
- MULT 0xFFFFFFFD × 5 → out_valid 33 cycles after accept, in_ready=0 during edges 0–32; then MFHI → 0xFFFFFFFF, MFLO → 0xFFFFFFF1.
- DIV 0xFFFFFFF9 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 → LO=0xFFFFFFFF, HI=7, div_by_zero=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, no flags. Opcode 0101 → result 0, illegal_op=1.
- reset_n low 10 cycles into a MULTU → outputs at reset values, HI=LO=0. After release, an ADD completes in 1 cycle.
- WIDTH=8 random sweep against a reference model, with in_valid toggling during BUSY. No op is lost or duplicated; MULT latency = 9.
